// File: rtl/jtframe_pack_pkg.sv
// Shared state encoding and sizing helper for the program-stream packer.
package jtframe_pack_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

   // Accumulator fill counter must hold values up to dw+7.
   function automatic int fill_width(input int dw);
      return $clog2(dw + 8);
   endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-port RAM on one clock: port 0 writes, port 1 reads with 1-cycle latency.
// A read of the address being written in the same cycle returns the old word.
module jtframe_dual_ram #(
   parameter int dw = 18,
   parameter int aw = 10
)(
   input  logic          clk,
   input  logic [dw-1:0] data0,
   input  logic [aw-1:0] addr0,
   input  logic          we0,
   input  logic [aw-1:0] addr1,
   output logic [dw-1:0] q1
);

   logic [dw-1:0] mem [0:(2**aw)-1];

   always_ff @(posedge clk) begin
      if (we0) mem[addr0] <= data0;
   end

   always_ff @(posedge clk) begin
      q1 <= mem[addr1];
   end

endmodule

// File: rtl/jtframe_prog_packer.sv
// Packs the 8-bit download stream LSB-first into DW-bit words held in a 2^AW x DW RAM; words land one
// cycle after the completing byte, no backpressure. JTFRAME_PACK_DESCRAMBLE_EN descrambles bytes with KEY.
module jtframe_prog_packer
   import jtframe_pack_pkg::*;
#(
   parameter int          DW  = 18,
   parameter int          AW  = 10,
   parameter logic [15:0] KEY = 16'h0
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          prog_en,
   input  logic          prog_wr,
   input  logic [7:0]    prog_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic [AW:0]   words,
   output logic [7:0]    cksum,
   output logic          done,
   output logic          ovf
);

   localparam int               FILLW = fill_width(DW);
   localparam int               ACCW  = DW + 7;
   localparam logic [FILLW-1:0] DW_F  = FILLW'(DW);
   localparam logic [AW:0]      DEPTH = (AW+1)'(1) << AW;

   state_t            state, nxt;
   logic              prog_en_l, rise, fall, start, accept;
   logic              commit, full, ram_we;
   logic [ACCW-1:0]   acc, acc_base, acc_sum;
   logic [FILLW-1:0]  fill, fill_base, fill_sum;
   logic              wr_pend;
   logic [DW-1:0]     wr_word, ram_din;
   logic [7:0]        pbyte;

   assign rise   = prog_en & ~prog_en_l;
   assign fall   = ~prog_en & prog_en_l;
   assign start  = rise && (state == IDLE || state == DONE);
   // The byte on the opening edge already belongs to the new stream
   assign accept = prog_en & prog_wr & (start | (state == LOAD));

`ifdef JTFRAME_PACK_DESCRAMBLE_EN
   logic [7:0] byte_idx, idx_cur, m, s1, s2;

   always_comb begin
      idx_cur = start ? 8'd0 : byte_idx;
      m       = idx_cur ^ KEY[7:0];
      s1      = prog_data;
      for (int i = 0; i < 4; i++)
         if (m[i]) s1[2*i +: 2] = {prog_data[2*i], prog_data[2*i+1]};
      s2      = s1 ^ KEY[15:8];
      pbyte   = s2;
      for (int i = 0; i < 4; i++)
         if (m[i+4]) pbyte[2*i +: 2] = {s2[2*i], s2[2*i+1]};
   end

   always_ff @(posedge clk) begin
      if (rst)         byte_idx <= 8'd0;
      else if (accept) byte_idx <= idx_cur + 8'd1;
   end
`else
   logic unused_key;
   assign unused_key = ^KEY;
   assign pbyte      = prog_data;
`endif

   assign acc_base  = start ? '0 : acc;
   assign fill_base = start ? '0 : fill;
   assign acc_sum   = acc_base | (ACCW'(pbyte) << fill_base);
   assign fill_sum  = fill_base + FILLW'(8);

   assign commit  = wr_pend | (state == FLUSH);
   assign full    = (words == DEPTH);
   assign ram_we  = commit & ~full & ~rst;
   assign ram_din = (state == FLUSH) ? acc[DW-1:0] : wr_word;
   assign done    = (state == DONE);

   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: if (rise) nxt = LOAD;
         LOAD:       if (fall) nxt = (fill != '0) ? FLUSH : DONE;
         FLUSH:      nxt = DONE;
         default:    nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prog_en_l <= 1'b0;
         acc       <= '0;
         fill      <= '0;
         wr_pend   <= 1'b0;
         wr_word   <= '0;
         words     <= '0;
         cksum     <= 8'd0;
         ovf       <= 1'b0;
      end else begin
         state     <= nxt;
         prog_en_l <= prog_en;
         wr_pend   <= 1'b0;
         if (start) begin
            words <= '0;
            cksum <= 8'd0;
            ovf   <= 1'b0;
            acc   <= '0;
            fill  <= '0;
         end else if (commit) begin
            // Words past the RAM depth are dropped and the address never wraps
            if (full) ovf   <= 1'b1;
            else      words <= words + (AW+1)'(1);
         end
         if (accept) begin
            cksum <= (start ? 8'd0 : cksum) + prog_data;
            if (fill_sum >= DW_F) begin
               wr_pend <= 1'b1;
               wr_word <= acc_sum[DW-1:0];
               acc     <= acc_sum >> DW;
               fill    <= fill_sum - DW_F;
            end else begin
               acc  <= acc_sum;
               fill <= fill_sum;
            end
         end
      end
   end

   jtframe_dual_ram #(.dw(DW), .aw(AW)) u_ram (
      .clk   (clk),
      .data0 (ram_din),
      .addr0 (words[AW-1:0]),
      .we0   (ram_we),
      .addr1 (rd_addr),
      .q1    (rd_data)
   );

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Drives one byte stream into two packer builds (DW=18/AW=10 and DW=8/AW=2) and checks them against
// a bit-position reference model of the packed stream.
module tb_jtframe_prog_packer;

   logic        clk = 1'b0;
   logic        rst, prog_en, prog_wr;
   logic [7:0]  prog_data;
   logic [9:0]  rd_addr;
   logic [17:0] rd18;
   logic [7:0]  rd8;
   logic [10:0] words18;
   logic [2:0]  words8;
   logic [7:0]  cksum18, cksum8;
   logic        done18, done8, ovf18, ovf8;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  sbytes [$];
   logic [17:0] m18 [0:1023];
   logic [7:0]  m8  [0:3];
   int          last_w18, last_w8, last_ck;

`ifdef JTFRAME_PACK_DESCRAMBLE_EN
   localparam bit DESC = 1'b1;
`else
   localparam bit DESC = 1'b0;
`endif

   always #5 clk = ~clk;

   jtframe_prog_packer #(.DW(18), .AW(10), .KEY(16'h0000)) u18 (
      .rst(rst), .clk(clk), .prog_en(prog_en), .prog_wr(prog_wr), .prog_data(prog_data),
      .rd_addr(rd_addr), .rd_data(rd18), .words(words18), .cksum(cksum18),
      .done(done18), .ovf(ovf18)
   );

   jtframe_prog_packer #(.DW(8), .AW(2), .KEY(16'h00FF)) u8 (
      .rst(rst), .clk(clk), .prog_en(prog_en), .prog_wr(prog_wr), .prog_data(prog_data),
      .rd_addr(rd_addr[1:0]), .rd_data(rd8), .words(words8), .cksum(cksum8),
      .done(done8), .ovf(ovf8)
   );

   function automatic logic [7:0] swap_pairs(input logic [7:0] b, input logic [3:0] sel);
      logic [7:0] r = b;
      for (int i = 0; i < 4; i++)
         if (sel[i]) begin
            r[2*i]   = b[2*i+1];
            r[2*i+1] = b[2*i];
         end
      return r;
   endfunction

   function automatic logic [7:0] model_byte(input int idx, input logic [15:0] key);
      logic [7:0] b = sbytes[idx];
      logic [7:0] m = idx[7:0] ^ key[7:0];
      if (DESC) begin
         b = swap_pairs(b, m[3:0]);
         b = b ^ key[15:8];
         b = swap_pairs(b, m[7:4]);
      end
      return b;
   endfunction

   // Word k holds stream bits [k*dw +: dw]; bits beyond the stream are zero
   function automatic logic [31:0] model_word(input int dw, input int k, input logic [15:0] key);
      logic [31:0] w = '0;
      logic [7:0]  b;
      for (int i = 0; i < dw; i++) begin
         int pos = k*dw + i;
         if (pos < sbytes.size()*8) begin
            b    = model_byte(pos/8, key);
            w[i] = b[pos%8];
         end
      end
      return w;
   endfunction

   task automatic begin_stream(input bit wr0, input logic [7:0] b);
      @(negedge clk);
      prog_en = 1'b1; prog_wr = wr0; prog_data = b;
      sbytes.delete();
      if (wr0) sbytes.push_back(b);
   endtask

   task automatic put_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin @(negedge clk); prog_wr = 1'b0; end
      @(negedge clk);
      prog_wr = 1'b1; prog_data = b;
      sbytes.push_back(b);
   endtask

   task automatic end_stream(input bit drop);
      @(negedge clk);
      prog_en = 1'b0; prog_wr = drop; prog_data = 8'($urandom);
      @(negedge clk);
      prog_wr = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_stream(input string tag, input bit aborted);
      int nbits, t18, t8, w18, w8, cs, nrd;
      logic [31:0] w;
      nbits = sbytes.size()*8;
      t18   = aborted ? nbits/18 : (nbits + 17)/18;
      t8    = nbits/8;
      w18   = (t18 > 1024) ? 1024 : t18;
      w8    = (t8 > 4) ? 4 : t8;
      cs    = 0;
      foreach (sbytes[i]) cs += int'(sbytes[i]);
      for (int k = 0; k < w18; k++) begin w = model_word(18, k, 16'h0000); m18[k] = w[17:0]; end
      for (int k = 0; k < w8; k++)  begin w = model_word(8, k, 16'h00FF);  m8[k]  = w[7:0];  end
      last_w18 = aborted ? 0 : w18;
      last_w8  = aborted ? 0 : w8;
      last_ck  = aborted ? 0 : cs % 256;

      n_cmp++; if (words18 !== 11'(last_w18)) begin n_bad++; $display("FAIL %s words18: got %0d want %0d", tag, words18, last_w18); end
      n_cmp++; if (words8 !== 3'(last_w8)) begin n_bad++; $display("FAIL %s words8: got %0d want %0d", tag, words8, last_w8); end
      n_cmp++; if (cksum18 !== 8'(last_ck)) begin n_bad++; $display("FAIL %s cksum18: got %h want %h", tag, cksum18, 8'(last_ck)); end
      n_cmp++; if (cksum8 !== 8'(last_ck)) begin n_bad++; $display("FAIL %s cksum8: got %h want %h", tag, cksum8, 8'(last_ck)); end
      n_cmp++; if (done18 !== !aborted) begin n_bad++; $display("FAIL %s done18: got %b want %b", tag, done18, !aborted); end
      n_cmp++; if (done8 !== !aborted) begin n_bad++; $display("FAIL %s done8: got %b want %b", tag, done8, !aborted); end
      n_cmp++; if (ovf18 !== (!aborted && t18 > 1024)) begin n_bad++; $display("FAIL %s ovf18: got %b want %b", tag, ovf18, (!aborted && t18 > 1024)); end
      n_cmp++; if (ovf8 !== (!aborted && t8 > 4)) begin n_bad++; $display("FAIL %s ovf8: got %b want %b", tag, ovf8, (!aborted && t8 > 4)); end

      nrd = (w18 > w8) ? w18 : w8;
      for (int a = 0; a < nrd; a++) begin
         rd_addr = 10'(a);
         @(negedge clk);
         if (a < w18) begin
            n_cmp++;
            if (rd18 !== m18[a]) begin n_bad++; $display("FAIL %s ram18[%0d]: got %h want %h", tag, a, rd18, m18[a]); end
         end
         if (a < w8) begin
            n_cmp++;
            if (rd8 !== m8[a]) begin n_bad++; $display("FAIL %s ram8[%0d]: got %h want %h", tag, a, rd8, m8[a]); end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; prog_en = 1'b0; prog_wr = 1'b0; prog_data = 8'd0; rd_addr = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (words18 !== 11'd0) begin n_bad++; $display("FAIL reset words18: got %0d want 0", words18); end
      n_cmp++; if (words8 !== 3'd0) begin n_bad++; $display("FAIL reset words8: got %0d want 0", words8); end
      n_cmp++; if (cksum18 !== 8'd0) begin n_bad++; $display("FAIL reset cksum18: got %h want 00", cksum18); end
      n_cmp++; if (done18 !== 1'b0) begin n_bad++; $display("FAIL reset done18: got %b want 0", done18); end
      n_cmp++; if (ovf18 !== 1'b0) begin n_bad++; $display("FAIL reset ovf18: got %b want 0", ovf18); end
      n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset done8: got %b want 0", done8); end
   endtask

   task automatic test_full_words;
      begin_stream(1'b1, 8'hFF);
      repeat (8) put_byte(8'hFF, 0);
      end_stream(1'b0);
      check_stream("full_words", 1'b0);
      n_cmp++; if (words18 !== 11'd4) begin n_bad++; $display("FAIL full_words const words18: got %0d want 4", words18); end
      n_cmp++; if (cksum18 !== 8'hF7) begin n_bad++; $display("FAIL full_words const cksum18: got %h want f7", cksum18); end
   endtask

   task automatic test_flush;
      begin_stream(1'b1, 8'h01);
      put_byte(8'h02, 1);
      put_byte(8'h03, 0);
      end_stream(1'b0);
      check_stream("flush", 1'b0);
      rd_addr = 10'd0;
      @(negedge clk);
      n_cmp++; if (rd18 !== 18'h30201) begin n_bad++; $display("FAIL flush const ram18[0]: got %h want 30201", rd18); end
   endtask

   task automatic test_overflow;
      begin_stream(1'b1, 8'h11);
      put_byte(8'h22, 0); put_byte(8'h33, 0); put_byte(8'h44, 2); put_byte(8'h55, 0);
      end_stream(1'b0);
      check_stream("overflow", 1'b0);
      n_cmp++; if (ovf8 !== 1'b1) begin n_bad++; $display("FAIL overflow const ovf8: got %b want 1", ovf8); end
   endtask

   task automatic test_descramble;
      begin_stream(1'b1, 8'h00);
      end_stream(1'b0);
      check_stream("descramble", 1'b0);
   endtask

   task automatic test_abort;
      begin_stream(1'b1, 8'($urandom));
      repeat (3) put_byte(8'($urandom), $urandom_range(0, 1));
      @(negedge clk); prog_wr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; prog_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_stream("abort", 1'b1);
      begin_stream(1'b1, 8'($urandom));
      repeat (4) put_byte(8'($urandom), 0);
      end_stream(1'b0);
      check_stream("after_abort", 1'b0);
   endtask

   task automatic test_idle_wr;
      repeat (3) begin
         @(negedge clk); prog_wr = 1'b1; prog_data = 8'($urandom);
         @(negedge clk); prog_wr = 1'b0;
      end
      @(negedge clk);
      n_cmp++; if (words18 !== 11'(last_w18)) begin n_bad++; $display("FAIL idle_wr words18: got %0d want %0d", words18, last_w18); end
      n_cmp++; if (cksum18 !== 8'(last_ck)) begin n_bad++; $display("FAIL idle_wr cksum18: got %h want %h", cksum18, 8'(last_ck)); end
      n_cmp++; if (words8 !== 3'(last_w8)) begin n_bad++; $display("FAIL idle_wr words8: got %0d want %0d", words8, last_w8); end
      n_cmp++; if (done18 !== 1'b1) begin n_bad++; $display("FAIL idle_wr done18: got %b want 1", done18); end
      begin_stream(1'b1, 8'hA5);
      put_byte(8'h5A, 0);
      end_stream(1'b1);
      check_stream("wr_on_rise", 1'b0);
   endtask

   task automatic test_random;
      for (int s = 0; s < 8; s++) begin
         int n = $urandom_range(1, 20);
         bit w0 = 1'($urandom_range(0, 1));
         begin_stream(w0, 8'($urandom));
         for (int j = (w0 ? 1 : 0); j < n; j++) put_byte(8'($urandom), $urandom_range(0, 2));
         end_stream(1'($urandom_range(0, 1)));
         check_stream($sformatf("random%0d", s), 1'b0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_full_words();
      test_flush();
      test_overflow();
      test_descramble();
      test_abort();
      test_idle_wr();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
